// File: rtl/spi_adc_reader_pkg.sv
// Shared types and default frame geometry for the serial ADC reader.
package adc_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    SHIFT = 3'd2,
    HOLD  = 3'd3,
    QUIET = 3'd4
  } adc_state_t;

  localparam int LEAD_BITS  = 4;
  localparam int ADC_BITS   = 12;
  localparam int FRAME_BITS = LEAD_BITS + ADC_BITS;

endpackage

// File: rtl/spi_adc_reader_if.sv
// SPI pins plus the sample stream that feeds the capture shift register.
interface spi_adc_if #(
  parameter int OUT_BITS = 10
);
  import adc_pkg::*;

  logic                i_enable;
  logic                i_miso;
  logic                o_cs_n;
  logic                o_sclk;
  logic [OUT_BITS-1:0] o_out;
  logic                o_valid;
  logic                o_lead_err;
  logic                o_busy;

  modport master (
    input  i_enable, i_miso,
    output o_cs_n, o_sclk, o_out, o_valid, o_lead_err, o_busy
  );

  modport slave (
    output i_enable, i_miso,
    input  o_cs_n, o_sclk, o_out, o_valid, o_lead_err, o_busy
  );

endinterface

// File: rtl/spi_adc_reader_tick_gen.sv
// SCLK generator: registered level idling high, with strobes one cycle ahead of each edge.
module spi_tick_gen #(
  parameter int CLK_DIV = 3
) (
  input  logic i_clk,
  input  logic i_clear,
  output logic o_rise,
  output logic o_fall,
  output logic o_sclk
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] cnt;
  logic          at_end;

  // Strobes are not gated by i_clear so the parent can derive i_clear from them.
  assign at_end = (cnt == CW'(CLK_DIV - 1));
  assign o_rise = at_end & ~o_sclk;
  assign o_fall = at_end & o_sclk;

  always_ff @(posedge i_clk) begin
    if (i_clear) begin
      cnt    <= '0;
      o_sclk <= 1'b1;
    end else if (at_end) begin
      cnt    <= '0;
      o_sclk <= ~o_sclk;
    end else begin
      cnt    <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/spi_adc_reader.sv
// SPI master / deserializer for an AD7476A-style 12-bit ADC; one truncated sample per frame.
module spi_adc_reader #(
  parameter int CLK_DIV      = 3,
  parameter int QUIET_CYCLES = 5,
  parameter int LEAD_BITS    = adc_pkg::LEAD_BITS,
  parameter int ADC_BITS     = adc_pkg::ADC_BITS,
  parameter int OUT_BITS     = 10
) (
  input logic        i_clk,
  input logic        i_rst,
  spi_adc_if.master  bus
);
  import adc_pkg::*;

  localparam int FRM_BITS = LEAD_BITS + ADC_BITS;
  localparam int BCW      = $clog2(FRM_BITS);
  localparam int PMAX     = (CLK_DIV > QUIET_CYCLES) ? CLK_DIV : QUIET_CYCLES;
  localparam int PCW      = (PMAX > 1) ? $clog2(PMAX) : 1;

  adc_state_t          state, state_nx;
  logic [FRM_BITS-1:0] shreg;
  logic [BCW-1:0]      bit_cnt;
  logic [PCW-1:0]      phase_cnt;
  logic                tick_clear, rise, fall, sclk_q;
  logic                run_now, run_nx;

  function automatic logic [OUT_BITS-1:0] sample_of(input logic [FRM_BITS-1:0] f);
    return f[ADC_BITS-1 -: OUT_BITS];
  endfunction

  function automatic logic lead_of(input logic [FRM_BITS-1:0] f);
    return |f[FRM_BITS-1:ADC_BITS];
  endfunction

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.i_enable) state_nx = SETUP;
      SETUP:   if (fall) state_nx = SHIFT;
      SHIFT:   if (fall && bit_cnt == BCW'(FRM_BITS - 1)) state_nx = HOLD;
      HOLD:    if (phase_cnt == '0) state_nx = QUIET;
      QUIET:   if (phase_cnt == '0) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // SETUP's length is the first SCLK high half; leaving SHIFT clears the
  // generator before its final fall can reach the pin.
  assign run_now    = (state == SETUP) || (state == SHIFT);
  assign run_nx     = (state_nx == SETUP) || (state_nx == SHIFT);
  assign tick_clear = i_rst | ~run_now | ~run_nx;

  spi_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .i_clk   (i_clk),
    .i_clear (tick_clear),
    .o_rise  (rise),
    .o_fall  (fall),
    .o_sclk  (sclk_q)
  );

  assign bus.o_sclk = sclk_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state          <= IDLE;
      bus.o_cs_n     <= 1'b1;
      bus.o_busy     <= 1'b0;
      bus.o_valid    <= 1'b0;
      bus.o_out      <= '0;
      bus.o_lead_err <= 1'b0;
      shreg          <= '0;
      bit_cnt        <= '0;
      phase_cnt      <= '0;
    end else begin
      state       <= state_nx;
      bus.o_cs_n  <= !(state_nx inside {SETUP, SHIFT, HOLD});
      bus.o_busy  <= (state_nx != IDLE);
      bus.o_valid <= 1'b0;

      if (state == SHIFT && rise) shreg <= {shreg[FRM_BITS-2:0], bus.i_miso};

      if (state != SHIFT)  bit_cnt <= '0;
      else if (fall)       bit_cnt <= bit_cnt + BCW'(1);

      if (state_nx != state) begin
        case (state_nx)
          HOLD:    phase_cnt <= PCW'(CLK_DIV - 1);
          QUIET:   phase_cnt <= PCW'(QUIET_CYCLES - 1);
          default: phase_cnt <= '0;
        endcase
      end else if (phase_cnt != '0) begin
        phase_cnt <= phase_cnt - PCW'(1);
      end

      // Sample is published even when the leading bits were corrupt.
      if (state == HOLD && state_nx == QUIET) begin
        bus.o_out      <= sample_of(shreg);
        bus.o_lead_err <= lead_of(shreg);
        bus.o_valid    <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_spi_adc_reader.sv
// Randomized bench for spi_adc_reader with a behavioural ADC and frame-level reference.
module tb_spi_adc_reader;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  spi_adc_if #(.OUT_BITS(10)) bus ();

  spi_adc_reader #(
    .CLK_DIV      (3),
    .QUIET_CYCLES (5),
    .LEAD_BITS    (4),
    .ADC_BITS     (12),
    .OUT_BITS     (10)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic check_val(input string tag, input longint got, input longint want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=0x%0h want=0x%0h", tag, got, want);
    end
  endtask

  function automatic longint ref_out(input logic [15:0] w);
    return longint'((w % 4096) / 4);
  endfunction

  function automatic longint ref_err(input logic [15:0] w);
    return (w >= 16'h1000) ? 1 : 0;
  endfunction

  // ADC model and observation log, sampled on the falling clock edge.
  int          cyc = 0;
  logic        prev_cs = 1'b1, prev_sclk = 1'b1;
  logic [15:0] cur_word = '0;
  int          rises_in_frame = 0;
  logic [15:0] word_q[$];
  int          rise_cyc[$];
  int          valid_cyc[$];
  longint      valid_out[$];
  longint      valid_err[$];
  int          cs_fall_cyc = 0, cs_rise_cyc = 0, cs_low_len = 0, cs_low_total = 0;

  always @(negedge clk) begin
    cyc++;
    if (bus.o_cs_n == 1'b0) cs_low_total++;
    if (prev_cs && !bus.o_cs_n) begin
      cs_fall_cyc    = cyc;
      cur_word       = (word_q.size() > 0) ? word_q.pop_front() : 16'h0000;
      rises_in_frame = 0;
      bus.i_miso     = cur_word[15];
    end
    if (!prev_cs && bus.o_cs_n) begin
      cs_rise_cyc = cyc;
      cs_low_len  = cyc - cs_fall_cyc;
    end
    if (!prev_sclk && bus.o_sclk) begin
      rise_cyc.push_back(cyc);
      rises_in_frame++;
    end
    if (prev_sclk && !bus.o_sclk && !bus.o_cs_n)
      bus.i_miso = (rises_in_frame < 16) ? cur_word[15 - rises_in_frame] : 1'b0;
    if (bus.o_valid) begin
      valid_cyc.push_back(cyc);
      valid_out.push_back(longint'(bus.o_out));
      valid_err.push_back(longint'(bus.o_lead_err));
    end
    prev_cs   = bus.o_cs_n;
    prev_sclk = bus.o_sclk;
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_log();
    rise_cyc.delete();
    valid_cyc.delete();
    valid_out.delete();
    valid_err.delete();
  endtask

  task automatic wait_cs_low(input int budget);
    int b = budget;
    while (bus.o_cs_n !== 1'b0 && b > 0) begin
      @(negedge clk);
      b--;
    end
    check_val("cs_fall_timeout", longint'(bus.o_cs_n), 0);
  endtask

  task automatic wait_valids(input int n, input int budget);
    int b = budget;
    while (valid_cyc.size() < n && b > 0) begin
      @(negedge clk);
      b--;
    end
    check_val("valid_timeout", valid_cyc.size(), n);
  endtask

  task automatic check_frames(input string tag, input logic [15:0] words[$], input int period);
    for (int i = 0; i < words.size() && i < valid_out.size(); i++) begin
      check_val({tag, "_out"}, valid_out[i], ref_out(words[i]));
      check_val({tag, "_err"}, valid_err[i], ref_err(words[i]));
      if (i > 0 && period > 0)
        check_val({tag, "_period"}, valid_cyc[i] - valid_cyc[i-1], period);
    end
  endtask

  initial begin
    logic [15:0] words[$];
    int good;
    int snap_rises;

    bus.i_enable = 1'b0;
    rst = 1'b1;
    cycles(3);
    check_val("rst_cs_n", longint'(bus.o_cs_n), 1);
    check_val("rst_sclk", longint'(bus.o_sclk), 1);
    check_val("rst_out", longint'(bus.o_out), 0);
    check_val("rst_valid", longint'(bus.o_valid), 0);
    check_val("rst_lead_err", longint'(bus.o_lead_err), 0);
    check_val("rst_busy", longint'(bus.o_busy), 0);
    rst = 1'b0;
    cs_low_total = 0;
    clear_log();

    // Disabled from reset: nothing moves.
    cycles(300);
    check_val("idle_cs_low", cs_low_total, 0);
    check_val("idle_rises", rise_cyc.size(), 0);
    check_val("idle_valids", valid_cyc.size(), 0);
    check_val("idle_busy", longint'(bus.o_busy), 0);
    check_val("idle_sclk", longint'(bus.o_sclk), 1);
    check_val("idle_out", longint'(bus.o_out), 0);

    // Single frame 0x0ABC, enable dropped at cycle 20 of the frame.
    clear_log();
    word_q.push_back(16'h0ABC);
    bus.i_enable = 1'b1;
    wait_cs_low(50);
    cycles(19);
    bus.i_enable = 1'b0;
    wait_valids(1, 400);
    cycles(2);
    check_val("cs_low_len", cs_low_len, 102);
    check_val("sclk_rises", rise_cyc.size(), 16);
    good = 0;
    for (int i = 1; i < rise_cyc.size(); i++)
      if (rise_cyc[i] - rise_cyc[i-1] == 6) good++;
    check_val("sclk_period", good, 15);
    if (valid_cyc.size() > 0) check_val("valid_at_cs_rise", valid_cyc[0], cs_rise_cyc);
    words = '{16'h0ABC};
    check_frames("abc", words, 0);
    snap_rises = rise_cyc.size();
    cycles(500);
    check_val("stop_valids", valid_cyc.size(), 1);
    check_val("stop_rises", rise_cyc.size(), snap_rises);
    check_val("stop_busy", longint'(bus.o_busy), 0);
    check_val("stop_cs_n", longint'(bus.o_cs_n), 1);
    check_val("stop_sclk", longint'(bus.o_sclk), 1);

    // Reset at cycle 40 of a frame, enable kept high.
    clear_log();
    word_q.push_back(16'h0ABC);
    word_q.push_back(16'h0123);
    bus.i_enable = 1'b1;
    wait_cs_low(50);
    cycles(39);
    rst = 1'b1;
    cycles(1);
    rst = 1'b0;
    check_val("abort_cs_n", longint'(bus.o_cs_n), 1);
    check_val("abort_sclk", longint'(bus.o_sclk), 1);
    check_val("abort_out", longint'(bus.o_out), 0);
    check_val("abort_valid", longint'(bus.o_valid), 0);
    cycles(1);
    check_val("restart_cs_n", longint'(bus.o_cs_n), 0);
    bus.i_enable = 1'b0;
    wait_valids(1, 400);
    check_val("abort_valids", valid_cyc.size(), 1);
    words = '{16'h0123};
    check_frames("restart", words, 0);
    cycles(150);

    // Back-to-back frames with enable held high.
    clear_log();
    words = '{16'h0FFF, 16'h0000, 16'h8123, 16'h0004};
    foreach (words[i]) word_q.push_back(words[i]);
    bus.i_enable = 1'b1;
    wait_valids(4, 600);
    bus.i_enable = 1'b0;
    check_frames("fixed", words, 108);
    cycles(150);

    // Randomized words, continuous conversion.
    clear_log();
    words.delete();
    for (int i = 0; i < 8; i++) words.push_back(16'($urandom_range(0, 65535)));
    foreach (words[i]) word_q.push_back(words[i]);
    bus.i_enable = 1'b1;
    wait_valids(8, 8 * 110 + 50);
    bus.i_enable = 1'b0;
    check_frames("rand", words, 108);
    cycles(150);
    check_val("final_busy", longint'(bus.o_busy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
